sram_arbiter: RTL and testbench

- Two-requester arbiter and access sequencer for the board's 1M x 16 asynchronous SRAM (IS61WV102416).
- Sits between two Avalon-MM-style masters (m0: processor data port; m1: pixel-buffer/DMA port) and the SRAM pins.
- Grants one master per access, round-robin, and generates CE_N/OE_N/WE_N/UB_N/LB_N timing.
- Drives and tri-states the shared data bus.

---
 rtl/sram_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-master arbiter and access sequencer for a 1M x 16 asynchronous SRAM.
// Build macro SRAM_ARB_M1_PRIORITY_EN gives master 1 strict priority; default is round-robin.
module sram_arbiter #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_waitrequest,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_waitrequest,
    output logic [ADDR_W-1:0]     sram_addr,
    inout  wire  [DATA_W-1:0]     sram_dq,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              is_write;
        logic              grant;
    } req_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    req_t               r_req;
    logic               r_last_grant;
    logic [ADDR_W-1:0]  r_sram_addr;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic               r_ub_n;
    logic               r_lb_n;
    logic               r_dq_oe;
    logic [DATA_W-1:0]  r_dq_out;
    logic               r_wait0;
    logic               r_wait1;
    logic [DATA_W-1:0]  r_rdata0;
    logic [DATA_W-1:0]  r_rdata1;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    req_t               w_req_nxt;
    logic               w_last_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_ce_nxt;
    logic               w_oe_nxt;
    logic               w_we_nxt;
    logic               w_ub_nxt;
    logic               w_lb_nxt;
    logic               w_dq_oe_nxt;
    logic [DATA_W-1:0]  w_dq_out_nxt;
    logic               w_wait0_nxt;
    logic               w_wait1_nxt;
    logic [DATA_W-1:0]  w_rdata0_nxt;
    logic [DATA_W-1:0]  w_rdata1_nxt;

    logic w_req0;
    logic w_req1;
    logic w_pick1;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

`ifdef SRAM_ARB_M1_PRIORITY_EN
    assign w_pick1 = w_req1;
`else
    // m1 wins a tie only when m0 was served last
    assign w_pick1 = w_req1 & (~w_req0 | ~r_last_grant);
`endif

    // Next-state logic, then decode of the strobes for the cycle being entered
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_req_nxt    = r_req;
        w_last_nxt   = r_last_grant;
        w_rdata0_nxt = r_rdata0;
        w_rdata1_nxt = r_rdata1;

        case (r_state)
            S_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_req_nxt.grant    = w_pick1;
                    w_req_nxt.addr     = w_pick1 ? m1_address    : m0_address;
                    w_req_nxt.be       = w_pick1 ? m1_byteenable : m0_byteenable;
                    w_req_nxt.wdata    = w_pick1 ? m1_writedata  : m0_writedata;
                    w_req_nxt.is_write = w_pick1 ? m1_write      : m0_write;
                    w_last_nxt         = w_pick1;
                    w_cnt_nxt          = '0;
                    w_state_nxt        = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                    w_state_nxt = S_DONE;
                    if (!r_req.is_write) begin
                        if (r_req.grant) begin
                            w_rdata1_nxt = sram_dq;
                        end else begin
                            w_rdata0_nxt = sram_dq;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_addr_nxt   = r_sram_addr;
        w_ce_nxt     = 1'b1;
        w_oe_nxt     = 1'b1;
        w_we_nxt     = 1'b1;
        w_ub_nxt     = 1'b1;
        w_lb_nxt     = 1'b1;
        w_dq_oe_nxt  = 1'b0;
        w_dq_out_nxt = w_req_nxt.wdata;
        w_wait0_nxt  = 1'b1;
        w_wait1_nxt  = 1'b1;

        case (w_state_nxt)
            S_ACCESS: begin
                w_addr_nxt = w_req_nxt.addr;
                w_ce_nxt   = 1'b0;
                w_ub_nxt   = ~w_req_nxt.be[1];
                w_lb_nxt   = ~w_req_nxt.be[0];
                if (w_req_nxt.is_write) begin
                    // no byte lanes enabled: run the cycle but never pulse WE
                    w_we_nxt    = ~(|w_req_nxt.be);
                    w_dq_oe_nxt = 1'b1;
                end else begin
                    w_oe_nxt = 1'b0;
                end
            end
            S_DONE: begin
                w_addr_nxt  = w_req_nxt.addr;
                w_ce_nxt    = 1'b0;
                w_ub_nxt    = ~w_req_nxt.be[1];
                w_lb_nxt    = ~w_req_nxt.be[0];
                w_dq_oe_nxt = w_req_nxt.is_write;
                w_wait0_nxt = w_req_nxt.grant;
                w_wait1_nxt = ~w_req_nxt.grant;
            end
            default: begin
            end
        endcase
    end

    // State and registered pin/handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_req        <= '0;
            r_last_grant <= 1'b1;
            r_sram_addr  <= '0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_ub_n       <= 1'b1;
            r_lb_n       <= 1'b1;
            r_dq_oe      <= 1'b0;
            r_dq_out     <= '0;
            r_wait0      <= 1'b1;
            r_wait1      <= 1'b1;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req        <= w_req_nxt;
            r_last_grant <= w_last_nxt;
            r_sram_addr  <= w_addr_nxt;
            r_ce_n       <= w_ce_nxt;
            r_oe_n       <= w_oe_nxt;
            r_we_n       <= w_we_nxt;
            r_ub_n       <= w_ub_nxt;
            r_lb_n       <= w_lb_nxt;
            r_dq_oe      <= w_dq_oe_nxt;
            r_dq_out     <= w_dq_out_nxt;
            r_wait0      <= w_wait0_nxt;
            r_wait1      <= w_wait1_nxt;
            r_rdata0     <= w_rdata0_nxt;
            r_rdata1     <= w_rdata1_nxt;
        end
    end

    assign sram_dq        = r_dq_oe ? r_dq_out : {DATA_W{1'bz}};
    assign sram_addr      = r_sram_addr;
    assign sram_ce_n      = r_ce_n;
    assign sram_oe_n      = r_oe_n;
    assign sram_we_n      = r_we_n;
    assign sram_ub_n      = r_ub_n;
    assign sram_lb_n      = r_lb_n;
    assign m0_waitrequest = r_wait0;
    assign m1_waitrequest = r_wait1;
    assign m0_readdata    = r_rdata0;
    assign m1_readdata    = r_rdata1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM pin model, completion scoreboard,
// vector table of single accesses, plus reset-abort and arbitration sequences.
module tb_sram_arbiter;

    localparam int unsigned ADDR_W      = 20;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned WAIT_CYCLES = 2;
    localparam int          LAT         = WAIT_CYCLES + 1;
    localparam int          PERIOD      = WAIT_CYCLES + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [1:0]        m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [ADDR_W-1:0] sram_addr;
    wire  [DATA_W-1:0] sram_dq;
    logic              sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model; the bench parks the bus at 0 while CE is high so a stray DUT drive shows up
    logic [15:0] mem [logic [19:0]];
    logic [15:0] model_rd = 16'h0;
    logic [15:0] wr_tmp;

    function automatic logic [15:0] mem_read(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0;
    endfunction

    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? model_rd :
                     (sram_ce_n ? 16'h0000 : 16'hzzzz);

    always @(negedge clk) model_rd <= mem_read(sram_addr);

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            wr_tmp = mem_read(sram_addr);
            if (!sram_lb_n) wr_tmp[7:0]  = sram_dq[7:0];
            if (!sram_ub_n) wr_tmp[15:8] = sram_dq[15:8];
            mem[sram_addr] = wr_tmp;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected completion per master, popped when waitrequest drops
    typedef struct {
        bit          is_read;
        logic [15:0] rdata;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   comp_m[$];
    int   comp_c[$];

    task automatic complete(input int m, input logic [15:0] rd);
        exp_t e;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_completion_m%0d", m), 32'd1, 32'd0);
            return;
        end
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        if (e.is_read) chk($sformatf("readdata_m%0d", m), 32'(rd), 32'(e.rdata));
        comp_m.push_back(m);
        comp_c.push_back(cyc);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (!m0_waitrequest) complete(0, m0_readdata);
            if (!m1_waitrequest) complete(1, m1_readdata);
            if (!m0_waitrequest && !m1_waitrequest) chk("both_wait_low", 32'd1, 32'd0);
            if (!sram_oe_n && !sram_we_n) chk("oe_we_overlap", 32'd1, 32'd0);
            if (sram_ce_n) chk("idle_bus_undriven", 32'(sram_dq), 32'h0);
        end
    end

    task automatic set_req(input int m, input logic rd, input logic wr, input logic [19:0] a,
                           input logic [1:0] be, input logic [15:0] wd);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
        end
    endtask

    function automatic logic get_wait(input int m);
        return (m == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    typedef struct {
        int          m;
        bit          rd;
        bit          wr;
        logic [19:0] addr;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        int          exp_we;
        int          exp_oe;
    } vec_t;

    vec_t vecs[12];

    // One isolated access: latency, strobe counts, lanes, data hold, bus release
    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        int          lat  = 0;
        int          we_c = 0;
        int          oe_c = 0;
        bit          done = 0;
        logic [15:0] dq_done = 16'h0;
        logic [1:0]  lanes;
        e.is_read = !v.wr;
        e.rdata   = v.exp_rd;
        lanes     = ~v.be;
        @(negedge clk);
        set_req(v.m, v.rd, v.wr, v.addr, v.be, v.wd);
        if (v.m == 0) q0.push_back(e); else q1.push_back(e);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!sram_we_n) we_c++;
            if (!sram_oe_n) oe_c++;
            if (lat == 1) begin
                chk($sformatf("v%0d_addr", idx), 32'(sram_addr), 32'(v.addr));
                chk($sformatf("v%0d_ce", idx), 32'(sram_ce_n), 32'd0);
                chk($sformatf("v%0d_lanes", idx), 32'({sram_ub_n, sram_lb_n}), 32'(lanes));
            end
            if (get_wait(v.m) == 1'b0) begin
                done    = 1;
                dq_done = sram_dq;
            end
        end
        set_req(v.m, 1'b0, 1'b0, 20'h0, 2'b00, 16'h0);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(LAT));
        chk($sformatf("v%0d_we_cycles", idx), 32'(we_c), 32'(v.exp_we));
        chk($sformatf("v%0d_oe_cycles", idx), 32'(oe_c), 32'(v.exp_oe));
        if (v.wr) chk($sformatf("v%0d_dq_hold", idx), 32'(dq_done), 32'(v.wd));
        @(negedge clk);
        chk($sformatf("v%0d_wait_one_cycle", idx), 32'(get_wait(v.m)), 32'd1);
        chk($sformatf("v%0d_bus_released", idx), 32'(sram_dq), 32'h0);
    endtask

    logic [19:0] s_addr[4];
    logic [15:0] s_exp[4];
    int          exp_ord[4];

    // Continuous reads: the next request is presented in the completion cycle
    task automatic stream(input int m, input int first, input int n);
        exp_t e;
        int   w;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            set_req(m, 1'b1, 1'b0, s_addr[first + k], 2'b11, 16'h0);
            e.is_read = 1;
            e.rdata   = s_exp[first + k];
            if (m == 0) q0.push_back(e); else q1.push_back(e);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (get_wait(m) != 1'b0 && w < 60);
            if (get_wait(m) != 1'b0) chk($sformatf("stream_m%0d_timeout", m), 32'd1, 32'd0);
        end
        set_req(m, 1'b0, 1'b0, 20'h0, 2'b00, 16'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        vec_t rv;

        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 20'h0, 2'b00, 16'h0);
        set_req(1, 1'b0, 1'b0, 20'h0, 2'b00, 16'h0);
        mem[20'h00123] = 16'hBEEF;
        mem[20'h7FFFF] = 16'h1111;
        mem[20'h00020] = 16'h5555;

        //          m  rd wr addr       be     wd        exp_rd    we oe
        vecs[0]  = '{0, 1, 0, 20'h00123, 2'b11, 16'h0000, 16'hBEEF, 0, 2};
        vecs[1]  = '{1, 0, 1, 20'h7FFFF, 2'b10, 16'hA55A, 16'h0000, 2, 0};
        vecs[2]  = '{1, 1, 0, 20'h7FFFF, 2'b11, 16'h0000, 16'hA511, 0, 2};
        vecs[3]  = '{0, 0, 1, 20'h00010, 2'b11, 16'h1234, 16'h0000, 2, 0};
        vecs[4]  = '{0, 1, 0, 20'h00010, 2'b11, 16'h0000, 16'h1234, 0, 2};
        vecs[5]  = '{1, 0, 1, 20'h00010, 2'b01, 16'hFFAB, 16'h0000, 2, 0};
        vecs[6]  = '{0, 1, 0, 20'h00010, 2'b11, 16'h0000, 16'h12AB, 0, 2};
        vecs[7]  = '{0, 0, 1, 20'h00020, 2'b00, 16'hDEAD, 16'h0000, 0, 0};
        vecs[8]  = '{1, 1, 0, 20'h00020, 2'b11, 16'h0000, 16'h5555, 0, 2};
        vecs[9]  = '{0, 1, 1, 20'hFFFFF, 2'b11, 16'h0F0F, 16'h0000, 2, 0};
        vecs[10] = '{1, 1, 0, 20'hFFFFF, 2'b11, 16'h0000, 16'h0F0F, 0, 2};
        vecs[11] = '{0, 1, 0, 20'h00000, 2'b01, 16'h0000, 16'h0000, 0, 2};

        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_wait", 32'({m0_waitrequest, m1_waitrequest}), 32'h3);
        chk("rst_rdata", 32'({m0_readdata, m1_readdata}), 32'h0);
        chk("rst_bus", 32'(sram_dq), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
        chk("ungranted_m1_rdata_kept", 32'(m1_readdata), 32'h0F0F);
        chk("m0_rdata_last", 32'(m0_readdata), 32'h0000);

        // Reset during the second ACCESS cycle of an m0 write
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 20'h00040, 2'b11, 16'h9999);
        q0.push_back('{0, 16'h0});
        repeat (2) @(negedge clk);
        chk("abort_in_access", 32'({sram_ce_n, sram_we_n}), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        chk("abort_addr", 32'(sram_addr), 32'h0);
        chk("abort_no_wait_pulse", 32'(m0_waitrequest), 32'd1);
        chk("abort_bus", 32'(sram_dq), 32'h0);
        reset = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (m0_waitrequest != 1'b0 && lat < 40);
        set_req(0, 1'b0, 1'b0, 20'h0, 2'b00, 16'h0);
        chk("abort_regrant_latency", 32'(lat), 32'(LAT));
        @(negedge clk);
        rv = '{0, 1, 0, 20'h00040, 2'b11, 16'h0000, 16'h9999, 0, 2};
        run_vec(12, rv);

        // Both masters streaming from reset
        s_addr[0] = 20'h00123; s_exp[0] = 16'hBEEF;
        s_addr[1] = 20'h7FFFF; s_exp[1] = 16'hA511;
        s_addr[2] = 20'h00010; s_exp[2] = 16'h12AB;
        s_addr[3] = 20'h00020; s_exp[3] = 16'h5555;
        pulse_reset();
        comp_m.delete();
        comp_c.delete();
`ifdef SRAM_ARB_M1_PRIORITY_EN
        exp_ord[0] = 1; exp_ord[1] = 1; exp_ord[2] = 1; exp_ord[3] = 0;
        fork
            stream(0, 3, 1);
            stream(1, 0, 3);
        join
`else
        exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0; exp_ord[3] = 1;
        fork
            stream(0, 0, 2);
            stream(1, 2, 2);
        join
`endif
        repeat (2) @(negedge clk);
        chk("arb_completions", 32'(comp_m.size()), 32'd4);
        for (int i = 0; i < 4 && i < comp_m.size(); i++) begin
            chk($sformatf("arb_order_%0d", i), 32'(comp_m[i]), 32'(exp_ord[i]));
            if (i > 0) chk($sformatf("arb_spacing_%0d", i), 32'(comp_c[i] - comp_c[i-1]), 32'(PERIOD));
        end

        chk("sb_m0_drained", 32'(q0.size()), 32'd0);
        chk("sb_m1_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
